// File: rtl/mac_array_ctrl_pkg.sv
// Shared types and constants for the mac_array_ctrl sequencer and its result buffer.
// Optional build macro used by the result buffer: MAC_ARRAY_CTRL_SAT_EN.
package mac_array_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_DRAIN,
        ST_OUTPUT,
        ST_DONE
    } ctrl_state_t;

    localparam int MAC_PIPE_LAT = 2;
    // The last mac_en cycle itself plus the MAC En->Cout latency.
    localparam int DRAIN_CYCLES = MAC_PIPE_LAT + 1;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_res_buf.sv
// ROWS-entry capture buffer for the MAC accumulators with indexed readout.
// MAC_ARRAY_CTRL_SAT_EN selects saturation instead of truncation on the readout path.
module mac_res_buf
    import mac_array_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cap_en,
    input  logic [ROWS*3*DATA_WIDTH-1:0]   mac_cout,
    input  logic [idx_width(ROWS)-1:0]     rd_idx,
    output logic [OUT_WIDTH-1:0]           rd_data
);

    localparam int CW = 3*DATA_WIDTH;

    logic [CW-1:0] res_q [ROWS];
    logic [CW-1:0] res_d [ROWS];
    logic [CW-1:0] sel;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            res_d[r] = cap_en ? mac_cout[r*CW +: CW] : res_q[r];
        end
    end

    // NOTE: the buffer is reset so res_data reads 0 out of reset; it is small enough that a flop reset costs nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                res_q[r] <= '0;
            end
        end else begin
            res_q <= res_d;
        end
    end

    assign sel = res_q[rd_idx];

    generate
        if (OUT_WIDTH >= CW) begin : g_wide
            assign rd_data = OUT_WIDTH'(sel);
        end else begin : g_narrow
`ifdef MAC_ARRAY_CTRL_SAT_EN
            assign rd_data = (|sel[CW-1:OUT_WIDTH]) ? '1 : sel[OUT_WIDTH-1:0];
`else
            logic sel_hi_unused;
            assign sel_hi_unused = ^sel[CW-1:OUT_WIDTH];
            assign rd_data       = sel[OUT_WIDTH-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for a ROWS-lane MAC bank computing y = A*b, streaming y over valid/ready.
// Build macro MAC_ARRAY_CTRL_SAT_EN: saturate results to OUT_WIDTH instead of truncating.
module mac_array_ctrl
    import mac_array_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic [idx_width(COLS)-1:0]     rd_addr,
    input  logic [ROWS*DATA_WIDTH-1:0]     a_rd_data,
    input  logic [DATA_WIDTH-1:0]          b_rd_data,
    output logic                           mac_en,
    output logic                           mac_clr,
    output logic [ROWS*DATA_WIDTH-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]          mac_b,
    input  logic [ROWS*3*DATA_WIDTH-1:0]   mac_cout,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [OUT_WIDTH-1:0]           res_data,
    output logic [idx_width(ROWS)-1:0]     res_idx
);

    localparam int CAW = idx_width(COLS);
    localparam int RIW = idx_width(ROWS);
    localparam logic [CAW-1:0] LAST_COL   = CAW'(COLS - 1);
    localparam logic [RIW-1:0] LAST_ROW   = RIW'(ROWS - 1);
    localparam logic [1:0]     LAST_DRAIN = 2'(DRAIN_CYCLES - 1);

    ctrl_state_t    state_q, state_d;
    logic [CAW-1:0] col_q, col_d;
    logic [1:0]     drain_q, drain_d;
    logic [RIW-1:0] idx_q, idx_d;
    logic           mac_en_q, mac_en_d;
    logic           capture;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            drain_q  <= '0;
            idx_q    <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            drain_q  <= drain_d;
            idx_q    <= idx_d;
            mac_en_q <= mac_en_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        drain_d   = drain_q;
        idx_d     = idx_q;
        mac_clr   = 1'b0;
        rd_en     = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clr = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                rd_en = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Cout of the final accumulate becomes visible on the last drain cycle.
                if (drain_q == LAST_DRAIN) begin
                    capture = 1'b1;
                    drain_d = '0;
                    state_d = ST_OUTPUT;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (idx_q == LAST_ROW) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mac_en_d = rd_en;
    end

    assign rd_addr = col_q;
    assign mac_en  = mac_en_q;
    assign mac_a   = a_rd_data;
    assign mac_b   = b_rd_data;
    assign res_idx = idx_q;

    mac_res_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ROWS),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_res_buf (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (capture),
        .mac_cout (mac_cout),
        .rd_idx   (idx_q),
        .rd_data  (res_data)
    );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: memory and MAC-bank models, a cycle-level
// reference derived from the run timeline, and directed scenarios with literal results.
module tb_mac_array_ctrl;
    import mac_array_ctrl_pkg::*;

    localparam int DW   = 8;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int OW   = 2*DW;
    localparam int CW   = 3*DW;
    localparam int CAW  = idx_width(COLS);
    localparam int RIW  = idx_width(ROWS);
    localparam longint OMAX = (longint'(1) << OW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;
    logic res_ready = 1'b1;
    int   cyc = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (COLS = 8) ----------------
    logic                 busy, done, rd_en, mac_en, mac_clr, res_valid;
    logic [CAW-1:0]       rd_addr;
    logic [ROWS*DW-1:0]   a_rd_data, mac_a;
    logic [DW-1:0]        b_rd_data, mac_b;
    logic [ROWS*CW-1:0]   mac_cout;
    logic [OW-1:0]        res_data;
    logic [RIW-1:0]       res_idx;

    mac_array_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cout(mac_cout), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx)
    );

    logic [DW-1:0] a_mem [COLS][ROWS];
    logic [DW-1:0] b_mem [COLS];
    logic          p_en, p_clr;
    logic [CW-1:0] p_prod [ROWS];
    logic [CW-1:0] acc [ROWS];

    always @(posedge clk) begin
        if (rd_en) begin
            for (int r = 0; r < ROWS; r++) a_rd_data[r*DW +: DW] <= a_mem[rd_addr][r];
            b_rd_data <= b_mem[rd_addr];
        end
        p_en  <= mac_en;
        p_clr <= mac_clr;
        for (int r = 0; r < ROWS; r++) begin
            p_prod[r] <= CW'(mac_a[r*DW +: DW]) * CW'(mac_b);
            if (p_clr)     acc[r] <= '0;
            else if (p_en) acc[r] <= acc[r] + p_prod[r];
        end
    end
    always_comb for (int r = 0; r < ROWS; r++) mac_cout[r*CW +: CW] = acc[r];

    // ---------------- second DUT (COLS = 1) ----------------
    logic                 busy1, done1, rd_en1, mac_en1, mac_clr1, res_valid1;
    logic [0:0]           rd_addr1;
    logic [ROWS*DW-1:0]   a_rd_data1, mac_a1;
    logic [DW-1:0]        b_rd_data1, mac_b1;
    logic [ROWS*CW-1:0]   mac_cout1;
    logic [OW-1:0]        res_data1;
    logic [RIW-1:0]       res_idx1;

    mac_array_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(1), .OUT_WIDTH(OW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .a_rd_data(a_rd_data1), .b_rd_data(b_rd_data1),
        .mac_en(mac_en1), .mac_clr(mac_clr1), .mac_a(mac_a1), .mac_b(mac_b1),
        .mac_cout(mac_cout1), .res_valid(res_valid1), .res_ready(res_ready),
        .res_data(res_data1), .res_idx(res_idx1)
    );

    logic [DW-1:0] a1_mem [ROWS];
    logic [DW-1:0] b1_mem;
    logic          p1_en, p1_clr;
    logic [CW-1:0] p1_prod [ROWS];
    logic [CW-1:0] acc1 [ROWS];

    always @(posedge clk) begin
        if (rd_en1 && rd_addr1 == 1'b0) begin
            for (int r = 0; r < ROWS; r++) a_rd_data1[r*DW +: DW] <= a1_mem[r];
            b_rd_data1 <= b1_mem;
        end
        p1_en  <= mac_en1;
        p1_clr <= mac_clr1;
        for (int r = 0; r < ROWS; r++) begin
            p1_prod[r] <= CW'(mac_a1[r*DW +: DW]) * CW'(mac_b1);
            if (p1_clr)     acc1[r] <= '0;
            else if (p1_en) acc1[r] <= acc1[r] + p1_prod[r];
        end
    end
    always_comb for (int r = 0; r < ROWS; r++) mac_cout1[r*CW +: CW] = acc1[r];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint reduce(input longint v);
`ifdef MAC_ARRAY_CTRL_SAT_EN
        return (v > OMAX) ? OMAX : v;
`else
        return v & OMAX;
`endif
    endfunction

    longint exp_y [ROWS];

    task automatic set_expect();
        for (int r = 0; r < ROWS; r++) begin
            longint s;
            s = 0;
            for (int k = 0; k < COLS; k++) s += longint'(a_mem[k][r]) * longint'(b_mem[k]);
            exp_y[r] = reduce(s);
        end
    endtask

    // Reference timeline: t counts cycles since the accepting start, hs counts handshakes.
    bit     m_active = 1'b0;
    int     m_t = 0;
    int     m_hs = 0;
    int     dut_hs = 0;
    longint first_data = -1;

    always @(negedge clk) begin
        bit e_clr, e_rd, e_en, e_rv, e_done;
        if (chk_on) begin
            e_clr  = m_active && m_t == 1;
            e_rd   = m_active && m_t >= 2 && m_t <= COLS + 1;
            e_en   = m_active && m_t >= 3 && m_t <= COLS + 2;
            e_rv   = m_active && m_t >= COLS + 5 && m_hs < ROWS;
            e_done = m_active && m_hs == ROWS;
            check("busy", busy, m_active);
            check("mac_clr", mac_clr, e_clr);
            check("rd_en", rd_en, e_rd);
            check("mac_en", mac_en, e_en);
            check("res_valid", res_valid, e_rv);
            check("done", done, e_done);
            if (e_rd) check("rd_addr", rd_addr, m_t - 2);
            if (e_rv) begin
                check("res_idx", res_idx, m_hs);
                check("res_data", res_data, exp_y[m_hs]);
            end
            if (res_valid && res_ready) begin
                dut_hs++;
                if (res_idx == 0) first_data = res_data;
            end
            if (rst) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_t      = 1;
                    m_hs     = 0;
                end
            end else if (e_done) begin
                m_active = 1'b0;
            end else begin
                if (e_rv && res_ready) m_hs++;
                m_t++;
            end
        end
    end

    task automatic load(input int a_val, input bit b_ramp, input int b_val);
        for (int k = 0; k < COLS; k++) begin
            for (int r = 0; r < ROWS; r++) a_mem[k][r] = DW'(a_val);
            b_mem[k] = b_ramp ? DW'(k + 1) : DW'(b_val);
        end
        set_expect();
    endtask

    task automatic run_and_wait(input string name, input int exp_lat);
        int s;
        bit seen;
        dut_hs     = 0;
        first_data = -1;
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, " done latency"}, seen ? cyc - s : -1, exp_lat);
        check({name, " handshakes"}, dut_hs, ROWS);
    endtask

    task automatic stall_at_idx2();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            if (res_valid && res_idx == RIW'(2)) begin
                hit = 1'b1;
                res_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        end
        check("stall reached idx 2", hit, 1);
    endtask

    task automatic stray_starts();
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bit seen;
        load(1, 1'b1, 0);
        for (int r = 0; r < ROWS; r++) a1_mem[r] = 8'd3;
        b1_mem = 8'd5;

        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset rd_en", rd_en, 0);
        check("reset mac_en", mac_en, 0);
        check("reset res_valid", res_valid, 0);
        check("reset res_data", res_data, 0);
        check("reset res_idx", res_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Column of ones
        run_and_wait("ones", 21);
        check("ones y0", first_data, 36);

        // Overflow
        load(255, 1'b0, 255);
        run_and_wait("overflow", 21);
`ifdef MAC_ARRAY_CTRL_SAT_EN
        check("overflow y0", first_data, 65535);
`else
        check("overflow y0", first_data, 61448);
`endif

        // Backpressure at idx 2
        load(1, 1'b1, 0);
        fork
            run_and_wait("backpressure", 24);
            stall_at_idx2();
        join
        check("backpressure y0", first_data, 36);

        // Back-to-back, stray starts ignored while busy
        fork
            run_and_wait("b2b first", 21);
            stray_starts();
        join
        load(1, 1'b0, 0);
        run_and_wait("b2b second", 21);
        check("b2b second y0", first_data, 0);

        // Reset mid-FETCH
        load(1, 1'b1, 0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post-reset busy", busy, 0);
        check("post-reset rd_en", rd_en, 0);
        check("post-reset mac_en", mac_en, 0);
        check("post-reset res_valid", res_valid, 0);
        run_and_wait("after reset", 21);
        check("after reset y0", first_data, 36);

        // COLS = 1 instance
        @(posedge clk); #1;
        start1 = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (res_valid1) seen = 1'b1;
        end
        check("cols1 res_valid latency", seen ? cyc - s : -1, 6);
        for (int i = 0; i < ROWS; i++) begin
            check("cols1 res_valid", res_valid1, 1);
            check("cols1 res_idx", res_idx1, i);
            check("cols1 res_data", res_data1, 15);
            @(negedge clk);
        end
        check("cols1 done", done1, 1);
        @(negedge clk);
        check("cols1 idle busy", busy1, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for a bank of `ROWS` MAC units computing one matrix-vector product y = A·b per run. A is `ROWS`×`COLS`; b has `COLS` elements. The block reads one column of A and one element of b per cycle from 1-cycle-latency memories, and drives the shared `En`/`Clr`/`Ain`/`Bin` of the MAC bank. It accounts for the MAC's 2-stage pipeline, captures the `ROWS` accumulators and streams them out over a valid/ready port.

## Interface
- `DATA_WIDTH`, 8: operand width; MAC `Cout` is 3*`DATA_WIDTH`.
- `ROWS`, 8: number of MAC lanes and result count.
- `COLS`, 8: dot-product length; `COLS` ≥ 1.
- `OUT_WIDTH`, 2*`DATA_WIDTH`: width of `res_data`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  starts a run when sampled in IDLE.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last result handshake.
- `rd_en`  out  1  read strobe to the A and b memories.
- `rd_addr`  out  $clog2(`COLS`)  column index k.
- `a_rd_data`  in  `ROWS`*`DATA_WIDTH`  column k of A; lane r in bits [r*DW +: DW]. Valid the cycle after `rd_en`.
- `b_rd_data`  in  `DATA_WIDTH`  b[k]; valid the cycle after `rd_en`.
- `mac_en`, `mac_clr`  out  1  broadcast to all MAC lanes.
- `mac_a`  out  `ROWS`*`DATA_WIDTH`  per-lane `Ain`.
- `mac_b`  out  `DATA_WIDTH`  broadcast `Bin`.
- `mac_cout`  in  `ROWS`*3*`DATA_WIDTH`  per-lane `Cout`.
- `res_valid`  out  1  result handshake valid.
- `res_ready`  in  1  result handshake ready.
- `res_data`  out  `OUT_WIDTH`  result y[`res_idx`].
- `res_idx`  out  $clog2(`ROWS`)  row index of `res_data`.

## Operation
- **States:** IDLE → CLEAR → FETCH → DRAIN → OUTPUT → DONE → IDLE.
- **IDLE:** if `start`=1, go to CLEAR. `start` in any other state is ignored; no queuing.
- **CLEAR:** exactly 1 cycle with `mac_clr`=1. This clears the accumulators at the start of every run.
- **FETCH:** exactly `COLS` cycles. `rd_en`=1 and `rd_addr`=k for k = 0..`COLS`-1.
- **MAC drive:** `mac_en` is `rd_en` delayed one cycle. `mac_a` and `mac_b` pass through `a_rd_data` and `b_rd_data` combinationally.
- **DRAIN:** exactly 3 cycles, covering the last `mac_en` plus the 2-cycle MAC En→Cout latency. On the last DRAIN cycle, all `ROWS` `mac_cout` values are registered into the result buffer.
- **OUTPUT:** `res_valid`=1 and `res_data`=buf[`res_idx`], with `res_idx` starting at 0.
  - Advance only on `res_valid`&&`res_ready`.
  - After the handshake with `res_idx`=`ROWS`-1, go to DONE.
- **DONE:** 1 cycle with `done`=1, then IDLE.
- **Width reduction to `OUT_WIDTH`:** see Configuration. Results are unsigned.
- **Reset values:** every output is 0, the state is IDLE, and the `mac_en` delay register is cleared.
  - Reset mid-run discards the run.
  - No `mac_en` is issued in the cycle after reset.
  - The MAC bank is not cleared by this block on reset; the next run's CLEAR handles it.

## Timing
- `start` is sampled at cycle 0.
- `mac_clr` is high at cycle 1.
- `rd_en` is high at cycles 2..`COLS`+1.
- `mac_en` is high at cycles 3..`COLS`+2.
- Capture happens at the end of cycle `COLS`+4.
- `res_valid` rises at cycle `COLS`+5.
- With `res_ready` held high: results occupy `COLS`+5..`COLS`+4+`ROWS`, and `done` is at cycle `COLS`+5+`ROWS`.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- A back-to-back `start` is accepted no earlier than the cycle after `done`.
- While `res_ready`=0: `res_data` and `res_idx` hold stable and `res_valid` stays high.

## Configuration
- `MAC_ARRAY_CTRL_SAT_EN`
  - Defined: a captured value ≥ 2^`OUT_WIDTH` outputs 2^`OUT_WIDTH`-1.
  - Undefined: the low `OUT_WIDTH` bits are output (truncation).
  - Both builds register the full 3*`DATA_WIDTH` value in the buffer; only the readout path differs.

## Structure
- **Package `mac_array_ctrl_pkg`:** state enum `ctrl_state_t`, `MAC_PIPE_LAT`=2, `DRAIN_CYCLES`=3.
- **Sub-module `mac_res_buf`:** `ROWS`-entry capture register plus indexed readout and the saturate/truncate stage.
- **Top level:** FSM, column counter, `mac_en` delay register, result index counter.

## Test plan
- **Column of ones:** `ROWS`=`COLS`=8, A all ones, b = 1..8 → eight results of 36, `res_idx` 0..7, `done` at cycle 21.
- **Overflow:** A = b = 255 everywhere → 520200 per row. Expect 65535 with `MAC_ARRAY_CTRL_SAT_EN` defined, 61448 without.
- **Backpressure:** `res_ready`=0 for 3 cycles while `res_idx`=2 → `res_data` and `res_idx` stable, no skipped or duplicated index, `done` delayed by 3 cycles.
- **Back-to-back runs:** run with b = 1..8, then start again with b all zero → second run outputs all zeros, proving CLEAR. `start` pulses during `busy` are ignored.
- **Reset mid-FETCH:** `rst` at cycle 4 → next cycle `busy`=`rd_en`=`mac_en`=`res_valid`=0. A fresh run then produces correct results (36 for the first scenario).
- **`COLS`=1 build:** A column = 3, b[0] = 5 → every result is 15, and `res_valid` rises at cycle 6.
